// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI decoder (master) and the voice allocator (slave).
interface voice_allocator_if #(
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7
);
    logic                  event_valid;
    logic                  event_ready;
    logic                  event_on;
    logic [NOTE_WIDTH-1:0] event_note;
    logic [VEL_WIDTH-1:0]  event_velocity;

    modport master (
        output event_valid,
        output event_on,
        output event_note,
        output event_velocity,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_on,
        input  event_note,
        input  event_velocity,
        output event_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: takes one note ON/OFF event at a time, scans the
// voices one per cycle, then retriggers a matching voice, takes a free one, or
// handles a full bank. Optional feature macro VOICE_ALLOC_STEAL_EN: when
// defined, a full bank steals the oldest voice; otherwise the ON is dropped.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int VEL_WIDTH  = 7
) (
    input  logic                             clock_50_000_000,
    input  logic                             reset,
    voice_allocator_if.slave                 evt,
    output logic [NUM_VOICES-1:0]            voice_gate,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]            voice_trigger,
    output logic                             event_dropped
);
    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam int               AGE_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;

    // Per-voice state; gate is kept directly in voice_gate.
    logic [NOTE_WIDTH-1:0] note_q [NUM_VOICES];
    logic [VEL_WIDTH-1:0]  vel_q  [NUM_VOICES];
    logic [AGE_W-1:0]      age_q  [NUM_VOICES];

    // Event latched at acceptance; the bus is ignored until the next IDLE.
    logic                  ev_on_q;
    logic [NOTE_WIDTH-1:0] ev_note_q;
    logic [VEL_WIDTH-1:0]  ev_vel_q;

    // Scan results.
    logic                  match_found;
    logic [IDX_W-1:0]      match_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
`ifdef VOICE_ALLOC_STEAL_EN
    logic [IDX_W-1:0]      old_idx;
    logic [AGE_W-1:0]      old_age;
`endif

    // Decision taken in APPLY.
    logic                  do_alloc;
    logic                  do_release;
    logic                  do_drop;
    logic [IDX_W-1:0]      target_idx;

    assign evt.event_ready = (state == IDLE) && !reset;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[g*NOTE_WIDTH +: NOTE_WIDTH] = note_q[g];
        assign voice_velocity[g*VEL_WIDTH +: VEL_WIDTH] = vel_q[g];
    end

    // Pick the voice an event acts on: match first, then free, then full-bank policy.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it holding a stale value (no latch).
        do_alloc   = 1'b0;
        do_release = 1'b0;
        do_drop    = 1'b0;
        target_idx = match_idx;
        if (ev_on_q) begin
            if (match_found) begin
                do_alloc = 1'b1;
            end else if (free_found) begin
                do_alloc   = 1'b1;
                target_idx = free_idx;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                do_alloc   = 1'b1;
                target_idx = old_idx;
`else
                do_drop    = 1'b1;
`endif
            end
        end else begin
            do_release = match_found;
        end
    end

    // Allocator FSM: accept, scan one voice per cycle, apply, with registered outputs.
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_vel_q      <= '0;
            match_found   <= 1'b0;
            match_idx     <= '0;
            free_found    <= 1'b0;
            free_idx      <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
            old_idx       <= '0;
            old_age       <= '0;
`endif
            voice_gate    <= '0;
            voice_trigger <= '0;
            event_dropped <= 1'b0;
            // NOTE: the voice arrays are reset like plain registers; they are small flops, not RAM, and the outputs must read 0 after reset.
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below sees the pre-edge state.
            voice_trigger <= '0;
            event_dropped <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (evt.event_valid) begin
                        ev_on_q     <= evt.event_on;
                        ev_note_q   <= evt.event_note;
                        ev_vel_q    <= evt.event_velocity;
                        match_found <= 1'b0;
                        match_idx   <= '0;
                        free_found  <= 1'b0;
                        free_idx    <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
                        old_idx     <= '0;
                        old_age     <= '0;
`endif
                        idx         <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_found && voice_gate[idx] && note_q[idx] == ev_note_q) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!free_found && !voice_gate[idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
`ifdef VOICE_ALLOC_STEAL_EN
                    // Strictly greater, so equal ages keep the lower index.
                    if (age_q[idx] > old_age) begin
                        old_age <= age_q[idx];
                        old_idx <= idx;
                    end
`endif
                    if (idx == LAST_IDX) begin
                        state <= APPLY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                APPLY: begin
                    if (do_alloc) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == target_idx) begin
                                voice_gate[i]    <= 1'b1;
                                note_q[i]        <= ev_note_q;
                                vel_q[i]         <= ev_vel_q;
                                age_q[i]         <= '0;
                                voice_trigger[i] <= 1'b1;
                            end else if (voice_gate[i] && age_q[i] != AGE_MAX) begin
                                age_q[i] <= age_q[i] + 1'b1;
                            end
                        end
                    end
                    if (do_release) begin
                        voice_gate[match_idx] <= 1'b0;
                    end
                    event_dropped <= do_drop;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (NUM_VOICES = 4): directed vector
// table, reset/back-to-back sequences, then random events against a model.
module tb_voice_allocator;
    localparam int NV      = 4;
    localparam int NW      = 7;
    localparam int VW      = 7;
    localparam int AGE_MAX = (1 << ($clog2(NV) + 1)) - 1;
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    typedef struct {
        logic [NV-1:0]    gate;
        logic [NV-1:0]    trig;
        logic             drop;
        logic [NV*NW-1:0] notes;
        logic [NV*VW-1:0] vels;
    } snap_t;

    typedef struct {
        bit               on;
        int               note;
        int               vel;
        logic [NV-1:0]    gate;
        logic [NV-1:0]    trig;
        logic             drop;
        logic [NV*NW-1:0] notes;
        logic [NV*VW-1:0] vels;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    voice_allocator_if #(.NOTE_WIDTH(NW), .VEL_WIDTH(VW)) ifc ();

    logic [NV-1:0]    voice_gate;
    logic [NV*NW-1:0] voice_note;
    logic [NV*VW-1:0] voice_velocity;
    logic [NV-1:0]    voice_trigger;
    logic             event_dropped;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .VEL_WIDTH(VW)) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .evt              (ifc),
        .voice_gate       (voice_gate),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_trigger    (voice_trigger),
        .event_dropped    (event_dropped)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of the voice bank.
    bit            m_gate [NV];
    int            m_note [NV];
    int            m_vel  [NV];
    int            m_age  [NV];
    logic [NV-1:0] m_trig;
    logic          m_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] p4(input int a3, input int a2, input int a1, input int a0);
        return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0;
            m_note[i] = 0;
            m_vel[i]  = 0;
            m_age[i]  = 0;
        end
        m_trig = '0;
        m_drop = 1'b0;
    endtask

    task automatic model_apply(input bit on, input int note, input int vel);
        int match, free, oldest, tgt;
        match  = -1;
        free   = -1;
        oldest = 0;
        tgt    = -1;
        m_trig = '0;
        m_drop = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (match < 0 && m_gate[i] && m_note[i] == note) match = i;
            if (free < 0 && !m_gate[i]) free = i;
            if (m_age[i] > m_age[oldest]) oldest = i;
        end
        if (on) begin
            if (match >= 0)     tgt = match;
            else if (free >= 0) tgt = free;
            else if (STEAL)     tgt = oldest;
            else                m_drop = 1'b1;
            if (tgt >= 0) begin
                for (int i = 0; i < NV; i++)
                    if (i != tgt && m_gate[i]) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
                m_gate[tgt] = 1'b1;
                m_note[tgt] = note;
                m_vel[tgt]  = vel;
                m_age[tgt]  = 0;
                m_trig[tgt] = 1'b1;
            end
        end else if (match >= 0) begin
            m_gate[match] = 1'b0;
        end
    endtask

    function automatic logic [NV-1:0] m_gate_vec();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_gate[i];
        return v;
    endfunction

    function automatic logic [NV*NW-1:0] m_note_vec();
        logic [NV*NW-1:0] v;
        for (int i = 0; i < NV; i++) v[i*NW +: NW] = NW'(m_note[i]);
        return v;
    endfunction

    function automatic logic [NV*VW-1:0] m_vel_vec();
        logic [NV*VW-1:0] v;
        for (int i = 0; i < NV; i++) v[i*VW +: VW] = VW'(m_vel[i]);
        return v;
    endfunction

    task automatic cmp_model(input string tag);
        check({tag, "_gate"},  voice_gate,     m_gate_vec());
        check({tag, "_note"},  voice_note,     m_note_vec());
        check({tag, "_vel"},   voice_velocity, m_vel_vec());
        check({tag, "_trig"},  voice_trigger,  m_trig);
        check({tag, "_drop"},  event_dropped,  m_drop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.event_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    // One event with full timing checks; returns the outputs seen in cycle T+NV+2.
    task automatic send(input bit on, input int note, input int vel, input string tag, output snap_t s);
        int waitc, bad_ready, bad_pulse;
        @(negedge clk);
        ifc.event_valid    = 1'b1;
        ifc.event_on       = on;
        ifc.event_note     = NW'(note);
        ifc.event_velocity = VW'(vel);
        waitc = 0;
        while (!ifc.event_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, "_accept"}, waitc < 50, 1'b1);
        @(posedge clk);
        #1;
        // Scramble the bus while the event is in flight; it must be ignored.
        ifc.event_valid    = 1'b0;
        ifc.event_on       = 1'($urandom);
        ifc.event_note     = NW'($urandom);
        ifc.event_velocity = VW'($urandom);
        model_apply(on, note, vel);
        bad_ready = 0;
        bad_pulse = 0;
        repeat (NV + 1) begin
            @(negedge clk);
            if (ifc.event_ready) bad_ready++;
            if (voice_trigger != '0 || event_dropped) bad_pulse++;
        end
        check({tag, "_ready_low"}, bad_ready, 0);
        check({tag, "_early_pulse"}, bad_pulse, 0);
        @(negedge clk);
        check({tag, "_ready_back"}, ifc.event_ready, 1'b1);
        cmp_model(tag);
        s.gate  = voice_gate;
        s.trig  = voice_trigger;
        s.drop  = event_dropped;
        s.notes = voice_note;
        s.vels  = voice_velocity;
        @(negedge clk);
        check({tag, "_pulse_end"}, {voice_trigger, event_dropped}, '0);
    endtask

    vec_t  tbl [10];
    snap_t snap;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, v0, first_rdy, bad;

        ifc.event_valid    = 1'b0;
        ifc.event_on       = 1'b0;
        ifc.event_note     = '0;
        ifc.event_velocity = '0;
        reset = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        check("ready_in_reset", ifc.event_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_gate",  voice_gate, '0);
        check("rst_note",  voice_note, '0);
        check("rst_vel",   voice_velocity, '0);
        check("rst_pulse", {voice_trigger, event_dropped}, '0);
        check("rst_ready", ifc.event_ready, 1'b1);

        // Directed table from reset; step 6 hits a full bank.
        n0 = STEAL ? 72 : 60;
        v0 = STEAL ? 55 : 40;
        tbl[0] = '{1'b1, 60, 100, 4'b0001, 4'b0001, 1'b0, p4(0, 0, 0, 60),    p4(0, 0, 0, 100)};
        tbl[1] = '{1'b1, 60, 40,  4'b0001, 4'b0001, 1'b0, p4(0, 0, 0, 60),    p4(0, 0, 0, 40)};
        tbl[2] = '{1'b1, 62, 90,  4'b0011, 4'b0010, 1'b0, p4(0, 0, 62, 60),   p4(0, 0, 90, 40)};
        tbl[3] = '{1'b1, 64, 80,  4'b0111, 4'b0100, 1'b0, p4(0, 64, 62, 60),  p4(0, 80, 90, 40)};
        tbl[4] = '{1'b1, 67, 70,  4'b1111, 4'b1000, 1'b0, p4(67, 64, 62, 60), p4(70, 80, 90, 40)};
        tbl[5] = '{1'b1, 72, 55,  4'b1111, STEAL ? 4'b0001 : 4'b0000, !STEAL, p4(67, 64, 62, n0), p4(70, 80, 90, v0)};
        tbl[6] = '{1'b0, 62, 0,   4'b1101, 4'b0000, 1'b0, p4(67, 64, 62, n0), p4(70, 80, 90, v0)};
        tbl[7] = '{1'b0, 62, 0,   4'b1101, 4'b0000, 1'b0, p4(67, 64, 62, n0), p4(70, 80, 90, v0)};
        tbl[8] = '{1'b1, 0,  0,   4'b1111, 4'b0010, 1'b0, p4(67, 64, 0, n0),  p4(70, 80, 0, v0)};
        tbl[9] = '{1'b0, 64, 0,   4'b1011, 4'b0000, 1'b0, p4(67, 64, 0, n0),  p4(70, 80, 0, v0)};
        for (int k = 0; k < 10; k++) begin
            send(tbl[k].on, tbl[k].note, tbl[k].vel, $sformatf("tbl%0d", k), snap);
            check($sformatf("tbl%0d_gate_const", k),  snap.gate,  tbl[k].gate);
            check($sformatf("tbl%0d_trig_const", k),  snap.trig,  tbl[k].trig);
            check($sformatf("tbl%0d_drop_const", k),  snap.drop,  tbl[k].drop);
            check($sformatf("tbl%0d_note_const", k),  snap.notes, tbl[k].notes);
            check($sformatf("tbl%0d_vel_const", k),   snap.vels,  tbl[k].vels);
        end

        // Reset in the middle of SCAN aborts the event.
        @(negedge clk);
        check("rsc_ready_before", ifc.event_ready, 1'b1);
        ifc.event_valid    = 1'b1;
        ifc.event_on       = 1'b1;
        ifc.event_note     = 7'd60;
        ifc.event_velocity = 7'd100;
        @(posedge clk);
        #1;
        ifc.event_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rsc_ready_in_reset", ifc.event_ready, 1'b0);
        reset = 1'b0;
        model_clear();
        #1;
        check("rsc_ready_after", ifc.event_ready, 1'b1);
        @(negedge clk);
        check("rsc_gate", voice_gate, '0);
        check("rsc_note", voice_note, '0);
        check("rsc_vel",  voice_velocity, '0);
        bad = 0;
        repeat (NV + 3) begin
            @(negedge clk);
            if (voice_gate != '0 || voice_trigger != '0 || event_dropped || !ifc.event_ready) bad++;
        end
        check("rsc_quiet", bad, 0);

        // Back-to-back: valid held with new data while the first event is in flight.
        do_reset();
        ifc.event_valid    = 1'b1;
        ifc.event_on       = 1'b1;
        ifc.event_note     = 7'd10;
        ifc.event_velocity = 7'd11;
        @(posedge clk);
        #1;
        model_apply(1'b1, 10, 11);
        ifc.event_note     = 7'd12;
        ifc.event_velocity = 7'd13;
        first_rdy = -1;
        for (int c = 1; c <= 3 * NV && first_rdy < 0; c++) begin
            @(negedge clk);
            if (ifc.event_ready) first_rdy = c;
        end
        check("b2b_accept_cycle", first_rdy, NV + 2);
        cmp_model("b2b_first");
        @(posedge clk);
        #1;
        ifc.event_valid = 1'b0;
        model_apply(1'b1, 12, 13);
        repeat (NV + 2) @(negedge clk);
        cmp_model("b2b_second");
        @(negedge clk);

        // Random events against the model; small note range forces matches and full banks.
        do_reset();
        for (int k = 0; k < 150; k++) begin
            bit on;
            int note, vel;
            on   = ($urandom_range(0, 9) < 7);
            note = ($urandom_range(0, 15) == 0) ? 127 : $urandom_range(0, 6);
            vel  = $urandom_range(0, 127);
            send(on, note, vel, $sformatf("rnd%0d", k), snap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the MIDI note-event decoder and a bank of `NUM_VOICES` oscillator voices. Accepts one note ON/OFF event at a time over a valid/ready handshake. Assigns the event to a voice, retriggering a voice already holding that note, taking a free voice, or stealing the oldest voice. Drives per-voice gate, note, velocity and a one-cycle phase-clear trigger.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of voices; power of two, 2..16.
- `NOTE_WIDTH`, 7: MIDI note-number width.
- `VEL_WIDTH`, 7: MIDI velocity width.

Ports:
- `clock_50_000_000`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `event_valid`  in  1  note event present.
- `event_ready`  out  1  allocator can accept an event.
- `event_on`  in  1  1 = note ON, 0 = note OFF.
- `event_note`  in  `NOTE_WIDTH`  note number.
- `event_velocity`  in  `VEL_WIDTH`  velocity. Ignored for OFF events.
- `voice_gate`  out  `NUM_VOICES`  bit i high while voice i sounds.
- `voice_note`  out  `NUM_VOICES*NOTE_WIDTH`  voice i occupies slice `[i*NOTE_WIDTH +: NOTE_WIDTH]`.
- `voice_velocity`  out  `NUM_VOICES*VEL_WIDTH`  packed the same way as `voice_note`.
- `voice_trigger`  out  `NUM_VOICES`  one-cycle pulse on voice i at a (re)start. Drives the oscillator `clear` input.
- `event_dropped`  out  1  one-cycle pulse when an ON event is discarded.

## Operation
- FSM states: IDLE, SCAN, APPLY.
- **IDLE:** `event_ready` = 1. When `event_valid && event_ready`, latch the on flag, note and velocity, clear the scan results, set index = 0, and go to SCAN.
- **SCAN:** examines voice[index], one voice per cycle, for index 0..`NUM_VOICES`-1. It records three results:
  - match: lowest index with gate = 1 and note = latched note;
  - free: lowest index with gate = 0;
  - oldest: highest age, with ties going to the lowest index.
  - After the last index, go to APPLY.
- **APPLY, ON event:** the first applicable case wins.
  1. Match → retrigger that voice: update velocity, pulse trigger, age = 0.
  2. Free → set gate = 1, note, velocity; pulse trigger; age = 0.
  3. Otherwise steal (see Configuration).
  - In every allocation, all other gated voices increment their age, saturating.
- **APPLY, OFF event:** match → gate = 0, with note, velocity and age left unchanged. No match → no state change and no pulse.
- From APPLY, go to IDLE.
- Age: per-voice counter, `$clog2(NUM_VOICES)+1` bits, saturating at all-ones. Reset value 0.
- A note is held by at most one voice at any time. A duplicate ON never creates a second voice.
- Note 0 and velocity 0 are ordinary values. A velocity-0 ON is treated as an ON.

## Timing
- Handshake accepted in cycle T. SCAN occupies T+1..T+`NUM_VOICES`. APPLY is cycle T+`NUM_VOICES`+1.
- Registered outputs change at the clock edge ending APPLY and are visible in cycle T+`NUM_VOICES`+2.
- `voice_trigger` and `event_dropped` are high for exactly that one cycle.
- `event_ready` = (state == IDLE) && !`reset`. It is low from T+1 until the cycle after APPLY, so the next event is accepted no earlier than T+`NUM_VOICES`+2.
- Throughput: one event per `NUM_VOICES`+2 cycles.
- `event_valid` without `event_ready` has no effect. The source holds the event until it is accepted.
- Reset values: all gates, notes, velocities, ages, triggers and `event_dropped` = 0; state = IDLE.
- Reset asserted mid-SCAN or mid-APPLY aborts the event with no output update. `event_ready` = 1 in the first cycle after reset deasserts.
- Inputs are sampled only at acceptance. Changes to `event_*` during SCAN or APPLY are ignored.

## Configuration
- Macro: `VOICE_ALLOC_STEAL_EN`.
- **Defined:** an ON event with no match and no free voice steals the oldest voice. The note and velocity are overwritten, gate stays 1, the trigger pulses and age becomes 0. `event_dropped` never pulses.
- **Undefined:** the same ON event is discarded. There are no voice changes, no age changes and no trigger pulse. `event_dropped` pulses one cycle in APPLY+1.

## Test plan
- Reset, then ON note 60 velocity 100 → cycle T+6 (N=4): `voice_gate`=0001, voice0 note 60, `voice_trigger`=0001 for one cycle. `event_ready` low T+1..T+5.
- ON 60, 62, 64, 67, then OFF 62 → gates 1111, then 1101. Voice1 note remains 62. A second OFF 62 → no change, no trigger.
- ON 60 twice (velocity 100, then 40) → still only voice0 gated. Velocity 40, trigger 0001 pulsed on each event.
- Four voices full (60, 62, 64, 67 in order), ON 72:
  - with `VOICE_ALLOC_STEAL_EN` → voice0 becomes 72, trigger 0001;
  - without → voices unchanged, `event_dropped` one pulse.
- Assert `reset` during SCAN of ON 60 → after reset, all outputs 0, no trigger, `event_ready` = 1 in the first cycle after deassert.
- Hold `event_valid` with new data throughout an in-flight event → the second event is accepted exactly in the cycle after APPLY and is allocated correctly.
